// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART frame sequencer driving the downstream 4:1 mux select and its data/parity inputs
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_READY,
    output logic [1:0]            MUX_SEL,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic                  BUSY
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0] cnt;
    logic par_en_q, par_bit_q, accept, last;
    assign accept = DATA_VALID & TX_READY;
    assign last = cnt == CW'(DATA_WIDTH - 1);
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? START : IDLE;
            START:   state_nx = DATA;
            DATA:    state_nx = !last ? DATA : (par_en_q ? PARITY : STOP);
            PARITY:  state_nx = STOP;
            STOP:    state_nx = accept ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        MUX_SEL  = state == START ? 2'b01 : state == DATA ? 2'b10 : state == PARITY ? 2'b11 : 2'b00;
        BUSY     = state != IDLE;
        TX_READY = state == IDLE || state == STOP;
        SER_DATA = shift_reg[0];
        PAR_BIT  = par_bit_q;
    end
    // Payload and parity are captured only on accept, so input changes mid-frame are invisible
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg <= '0;
            cnt       <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            if (accept) begin
                shift_reg <= P_DATA;
                par_en_q  <= PAR_EN;
                par_bit_q <= ^P_DATA ^ PAR_TYP;
            end else if (state == DATA) begin
                shift_reg <= shift_reg >> 1;
            end
            if (state == START) cnt <= '0;
            else if (state == DATA && !last) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed self-checking bench for uart_tx_fsm
module tb_uart_tx_fsm;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_READY, SER_DATA, PAR_BIT, BUSY;
    logic [1:0] MUX_SEL;
    int tests = 0;
    int fails = 0;

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_READY(TX_READY),
        .MUX_SEL(MUX_SEL), .SER_DATA(SER_DATA), .PAR_BIT(PAR_BIT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sel"}, {6'd0, MUX_SEL}, 8'd0);
        chk({tag, "_busy"}, {7'd0, BUSY}, 8'd0);
        chk({tag, "_rdy"}, {7'd0, TX_READY}, 8'd1);
    endtask

    // Entered #1 after the accepting edge (state START); leaves in STOP
    task automatic frame_check(input string tag, input logic [7:0] d, input logic pen, input logic pb);
        chk({tag, "_start_sel"}, {6'd0, MUX_SEL}, 8'h01);
        chk({tag, "_start_busy"}, {7'd0, BUSY}, 8'd1);
        chk({tag, "_start_rdy"}, {7'd0, TX_READY}, 8'd0);
        chk({tag, "_start_par"}, {7'd0, PAR_BIT}, {7'd0, pb});
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("%s_d%0d_sel", tag, i), {6'd0, MUX_SEL}, 8'h02);
            chk($sformatf("%s_d%0d_bit", tag, i), {7'd0, SER_DATA}, {7'd0, d[i]});
            chk($sformatf("%s_d%0d_busy", tag, i), {7'd0, BUSY}, 8'd1);
        end
        if (pen) begin
            tick();
            chk({tag, "_par_sel"}, {6'd0, MUX_SEL}, 8'h03);
            chk({tag, "_par_bit"}, {7'd0, PAR_BIT}, {7'd0, pb});
        end
        tick();
        chk({tag, "_stop_sel"}, {6'd0, MUX_SEL}, 8'h00);
        chk({tag, "_stop_busy"}, {7'd0, BUSY}, 8'd1);
        chk({tag, "_stop_rdy"}, {7'd0, TX_READY}, 8'd1);
        chk({tag, "_stop_par"}, {7'd0, PAR_BIT}, {7'd0, pb});
    endtask

    task automatic accept(input logic [7:0] d, input logic pen, input logic ptyp);
        P_DATA = d;
        PAR_EN = pen;
        PAR_TYP = ptyp;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        P_DATA = ~d;
        PAR_EN = ~pen;
        PAR_TYP = ~ptyp;
    endtask

    initial begin
        #3;
        chk("rst_sel", {6'd0, MUX_SEL}, 8'd0);
        chk("rst_busy", {7'd0, BUSY}, 8'd0);
        chk("rst_rdy", {7'd0, TX_READY}, 8'd1);
        chk("rst_ser", {7'd0, SER_DATA}, 8'd0);
        chk("rst_par", {7'd0, PAR_BIT}, 8'd0);
        #9 RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle($sformatf("idle%0d", i));
        end
        // 0xA5 even parity: four ones -> 0
        accept(8'hA5, 1'b1, 1'b0);
        frame_check("a5", 8'hA5, 1'b1, 1'b0);
        tick();
        chk_idle("a5_after");
        // 0x07 has three ones
        accept(8'h07, 1'b1, 1'b1);
        frame_check("o07", 8'h07, 1'b1, 1'b0);
        tick();
        chk_idle("o07_after");
        accept(8'h07, 1'b1, 1'b0);
        frame_check("e07", 8'h07, 1'b1, 1'b1);
        tick();
        chk_idle("e07_after");
        accept(8'h07, 1'b0, 1'b0);
        frame_check("n07", 8'h07, 1'b0, 1'b1);
        tick();
        chk_idle("n07_after");
        // Back-to-back: DATA_VALID held high throughout the first frame
        P_DATA = 8'h3C;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        DATA_VALID = 1'b1;
        tick();
        P_DATA = 8'hC3;
        PAR_TYP = 1'b1;
        frame_check("b1", 8'h3C, 1'b1, 1'b0);
        tick();
        DATA_VALID = 1'b0;
        frame_check("b2", 8'hC3, 1'b1, 1'b1);
        tick();
        chk_idle("b2_after");
        // Pulse during DATA must be ignored
        accept(8'h00, 1'b0, 1'b0);
        chk("ign_start_sel", {6'd0, MUX_SEL}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            DATA_VALID = (i == 3);
            P_DATA = 8'hFF;
            tick();
            chk($sformatf("ign_d%0d_sel", i), {6'd0, MUX_SEL}, 8'h02);
            chk($sformatf("ign_d%0d_bit", i), {7'd0, SER_DATA}, 8'd0);
        end
        DATA_VALID = 1'b0;
        chk("ign_par", {7'd0, PAR_BIT}, 8'd0);
        tick();
        chk("ign_stop_sel", {6'd0, MUX_SEL}, 8'h00);
        chk("ign_stop_busy", {7'd0, BUSY}, 8'd1);
        tick();
        chk_idle("ign_after");
        tick();
        chk_idle("ign_after2");
        // Asynchronous reset in the 4th DATA cycle
        accept(8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_sel_pre", {6'd0, MUX_SEL}, 8'h02);
        chk("mid_par_pre", {7'd0, PAR_BIT}, 8'd1);
        #2 RST = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_ser", {7'd0, SER_DATA}, 8'd0);
        chk("mid_rst_par", {7'd0, PAR_BIT}, 8'd0);
        #2 RST = 1'b1;
        tick();
        chk_idle("post_rst");
        accept(8'h5A, 1'b1, 1'b0);
        frame_check("r5a", 8'h5A, 1'b1, 1'b0);
        tick();
        chk_idle("r5a_after");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
